// File: rtl/pipereg_pkg.sv
// Shared defaults and width helpers for the valid/ready pipeline register chain.
package pipereg_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDepth = 2;

  // Counter must represent 0..2*depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipereg_skid.sv
// One full-throughput skid stage: registered data and registered ready.
module pipereg_skid
  import pipereg_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [WIDTH-1:0] w_data,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [WIDTH-1:0] r_data
);

  logic             main_valid_q;
  logic [WIDTH-1:0] main_data_q;
  logic             skid_valid_q;
  logic [WIDTH-1:0] skid_data_q;
  logic             acc;
  logic             emit;

  // Ready depends only on local state plus flush/reset, never on r_ready.
  assign w_ready = !skid_valid_q && !flush && !reset;
  assign acc     = w_valid && w_ready;
  assign emit    = main_valid_q && r_ready;
  assign r_valid = main_valid_q;
  assign r_data  = main_data_q;

  // Data registers are intentionally left untouched by reset/flush.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (skid_valid_q) begin
      if (emit) begin
        main_data_q  <= skid_data_q;
        skid_valid_q <= 1'b0;
      end
    end else if (acc && (!main_valid_q || emit)) begin
      main_data_q  <= w_data;
      main_valid_q <= 1'b1;
    end else if (acc) begin
      skid_data_q  <= w_data;
      skid_valid_q <= 1'b1;
    end else if (emit) begin
      main_valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pipereg_chain.sv
// DEPTH skid stages in series with a registered occupancy count and synchronous flush.
module pipereg_chain
  import pipereg_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [WIDTH-1:0] w_data,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [WIDTH-1:0] r_data,
  output logic [CNT_W-1:0] occupancy
);

  logic             valid_chain [DEPTH+1];
  logic             ready_chain [DEPTH+1];
  logic [WIDTH-1:0] data_chain  [DEPTH+1];
  logic [CNT_W-1:0] occ_q;
  logic             in_xfer;
  logic             out_xfer;

  assign valid_chain[0]     = w_valid;
  assign data_chain[0]      = w_data;
  assign w_ready            = ready_chain[0];
  assign r_valid            = valid_chain[DEPTH];
  assign r_data             = data_chain[DEPTH];
  assign ready_chain[DEPTH] = r_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipereg_skid #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clock  (clock),
      .reset  (reset),
      .flush  (flush),
      .w_valid(valid_chain[k]),
      .w_ready(ready_chain[k]),
      .w_data (data_chain[k]),
      .r_valid(valid_chain[k+1]),
      .r_ready(ready_chain[k+1]),
      .r_data (data_chain[k+1])
    );
  end

  assign in_xfer  = w_valid && w_ready;
  assign out_xfer = r_valid && r_ready;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      occ_q <= '0;
    end else if (in_xfer && !out_xfer) begin
      occ_q <= occ_q + CNT_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occ_q <= occ_q - CNT_W'(1);
    end
  end

  assign occupancy = occ_q;

endmodule
